// File: rtl/shift_right_pipe_pkg.sv
// Shared constants and payload types for the pipelined right shifter.
package shift_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned SHAMT_W    = 5;
  localparam int unsigned NUM_STAGES = 5;
  localparam int unsigned TAG_W_DEF  = 5;

  typedef enum logic {
    SHR_LOGIC = 1'b0,
    SHR_ARITH = 1'b1
  } shift_kind_e;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      data;
    logic [SHAMT_W-1:0]   shamt;
    logic                 arith;
    logic [TAG_W_DEF-1:0] tag;
  } shift_stage_t;

endpackage

// File: rtl/shift_right_pipe_if.sv
// Op/result handshake bundle for shift_right_pipe; slave is the shifter side.
interface shift_right_pipe_if
  import shift_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF
);
  logic               i_valid;
  logic               o_ready;
  logic [XLEN-1:0]    i_data;
  logic [SHAMT_W-1:0] i_shamt;
  logic               i_arith;
  logic [TAG_W-1:0]   i_tag;
  logic               o_valid;
  logic               i_ready;
  logic [XLEN-1:0]    o_data;
  logic [TAG_W-1:0]   o_tag;

  modport slave (
    input  i_valid, i_data, i_shamt, i_arith, i_tag, i_ready,
    output o_ready, o_valid, o_data, o_tag
  );

  modport master (
    output i_valid, i_data, i_shamt, i_arith, i_tag, i_ready,
    input  o_ready, o_valid, o_data, o_tag
  );
endinterface

// File: rtl/shift_right_pipe_stage.sv
// One barrel stage: conditionally shifts right by STEP using shamt bit log2(STEP).
module shift_right_stage
  import shift_pkg::*;
#(
  parameter int unsigned STEP = 1,
  parameter type         stage_t = shift_stage_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   adv_i,
  input  stage_t stage_i,
  output stage_t stage_o
);

  localparam int unsigned BIT = $clog2(STEP);

  stage_t stage_d;
  stage_t stage_q;
  logic   fill;

  // The MSB survives every earlier SRA stage, so it is still the original sign.
  always_comb begin
    stage_d = stage_i;
    fill    = (shift_kind_e'(stage_i.arith) == SHR_ARITH) && stage_i.data[XLEN-1];
    if (stage_i.shamt[BIT]) begin
      stage_d.data = {{STEP{fill}}, stage_i.data[XLEN-1:STEP]};
    end
    stage_d.shamt[BIT] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else if (adv_i) begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/shift_right_pipe.sv
// 5-stage registered SRL/SRA with valid/ready flow control and a pass-through tag.
module shift_right_pipe
  import shift_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  shift_right_pipe_if.slave bus
);

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    data;
    logic [SHAMT_W-1:0] shamt;
    logic               arith;
    logic [TAG_W-1:0]   tag;
  } stage_t;

  stage_t stage_in;
  stage_t stage_out [NUM_STAGES];
  logic   adv;

  // Global stall: the whole pipe advances whenever the output slot is free or draining.
  always_comb begin
    adv = !stage_out[NUM_STAGES-1].valid || bus.i_ready;
  end

  always_comb begin
    stage_in.valid = bus.i_valid;
    stage_in.data  = bus.i_data;
    stage_in.shamt = bus.i_shamt;
    stage_in.arith = bus.i_arith;
    stage_in.tag   = bus.i_tag;
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      shift_right_stage #(
        .STEP    (1 << k),
        .stage_t (stage_t)
      ) u_stage (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .adv_i   (adv),
        .stage_i (stage_in),
        .stage_o (stage_out[k])
      );
    end else begin : g_next
      shift_right_stage #(
        .STEP    (1 << k),
        .stage_t (stage_t)
      ) u_stage (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .adv_i   (adv),
        .stage_i (stage_out[k-1]),
        .stage_o (stage_out[k])
      );
    end
  end

  assign bus.o_ready = adv;
  assign bus.o_valid = stage_out[NUM_STAGES-1].valid;
  assign bus.o_data  = stage_out[NUM_STAGES-1].data;
  assign bus.o_tag   = stage_out[NUM_STAGES-1].tag;

endmodule

// File: tb/tb_shift_right_pipe.sv
// Directed bench for shift_right_pipe: vector table plus throughput, stall and reset sequences.
module tb_shift_right_pipe;

  localparam int unsigned TAG_W = 5;
  localparam int NV = 11;

  logic clk;
  logic rst_n;

  shift_right_pipe_if #(.TAG_W(TAG_W)) bus ();

  shift_right_pipe #(.TAG_W(TAG_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      data;
    logic [4:0]       shamt;
    logic             arith;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
  } vec_t;

  vec_t vecs [NV];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_op(input int idx);
    bus.i_valid = 1'b1;
    bus.i_data  = vecs[idx].data;
    bus.i_shamt = vecs[idx].shamt;
    bus.i_arith = vecs[idx].arith;
    bus.i_tag   = vecs[idx].tag;
  endtask

  task automatic run_single(input int idx);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    @(negedge clk);
    drive_op(idx);
    while (!got && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) bus.i_valid = 1'b0;
      if (bus.o_valid) got = 1'b1;
    end
    check($sformatf("vec%0d latency", idx), n, 5);
    check($sformatf("vec%0d data", idx), bus.o_data, vecs[idx].exp);
    check($sformatf("vec%0d tag", idx), {27'd0, bus.o_tag}, {27'd0, vecs[idx].tag});
  endtask

  initial begin
    int q[$];
    int sent;
    int recv;
    bit last_hold;
    logic [31:0] prev_data;
    logic [TAG_W-1:0] prev_tag;

    vecs[0]  = '{32'h12345678, 5'd8,  1'b0, 5'd3,  32'h00123456};
    vecs[1]  = '{32'hF0000000, 5'd4,  1'b1, 5'd4,  32'hFF000000};
    vecs[2]  = '{32'hF0000000, 5'd4,  1'b0, 5'd5,  32'h0F000000};
    vecs[3]  = '{32'h80000000, 5'd31, 1'b1, 5'd6,  32'hFFFFFFFF};
    vecs[4]  = '{32'h80000000, 5'd31, 1'b0, 5'd7,  32'h00000001};
    vecs[5]  = '{32'hDEADBEEF, 5'd0,  1'b1, 5'd8,  32'hDEADBEEF};
    vecs[6]  = '{32'h7FFFFFFF, 5'd31, 1'b1, 5'd9,  32'h00000000};
    vecs[7]  = '{32'h80000000, 5'd1,  1'b1, 5'd10, 32'hC0000000};
    vecs[8]  = '{32'hA5A5A5A5, 5'd16, 1'b0, 5'd11, 32'h0000A5A5};
    vecs[9]  = '{32'h89ABCDEF, 5'd12, 1'b1, 5'd31, 32'hFFF89ABC};
    vecs[10] = '{32'h0000FFFF, 5'd5,  1'b0, 5'd0,  32'h000007FF};

    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_shamt = '0;
    bus.i_arith = 1'b0;
    bus.i_tag   = '0;
    bus.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset o_valid", {31'd0, bus.o_valid}, 32'd0);
    check("reset o_data", bus.o_data, 32'd0);
    check("reset o_tag", {27'd0, bus.o_tag}, 32'd0);
    check("reset o_ready", {31'd0, bus.o_ready}, 32'd1);

    for (int i = 0; i < NV; i++) run_single(i);

    // Back-to-back: 8 ops, results expected on iterations 5..12.
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int it = 0; it < 16; it++) begin
      @(negedge clk);
      if (it >= 5 && it < 13) begin
        check($sformatf("thru it%0d valid", it), {31'd0, bus.o_valid}, 32'd1);
        check($sformatf("thru it%0d data", it), bus.o_data, vecs[it-5].exp);
        check($sformatf("thru it%0d tag", it), {27'd0, bus.o_tag}, {27'd0, vecs[it-5].tag});
      end else begin
        check($sformatf("thru it%0d idle", it), {31'd0, bus.o_valid}, 32'd0);
      end
      if (it < 8) drive_op(it);
      else bus.i_valid = 1'b0;
    end

    // Backpressure: i_ready low for three cycles while results are waiting.
    repeat (3) @(negedge clk);
    sent = 0;
    recv = 0;
    last_hold = 1'b0;
    prev_data = '0;
    prev_tag = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      bus.i_ready = !(cyc >= 6 && cyc <= 8);
      if (sent < 10) drive_op(sent);
      else bus.i_valid = 1'b0;
      #1;
      if (last_hold) begin
        check($sformatf("bp c%0d hold data", cyc), bus.o_data, prev_data);
        check($sformatf("bp c%0d hold tag", cyc), {27'd0, bus.o_tag}, {27'd0, prev_tag});
      end
      if (bus.o_valid && !bus.i_ready) begin
        check($sformatf("bp c%0d o_ready", cyc), {31'd0, bus.o_ready}, 32'd0);
      end
      if (bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) begin
          check($sformatf("bp c%0d unexpected", cyc), bus.o_data, 32'hxxxxxxxx);
        end else begin
          check($sformatf("bp c%0d data", cyc), bus.o_data, vecs[q[0]].exp);
          check($sformatf("bp c%0d tag", cyc), {27'd0, bus.o_tag}, {27'd0, vecs[q[0]].tag});
          void'(q.pop_front());
        end
        recv++;
      end
      if (bus.i_valid && bus.o_ready) begin
        q.push_back(sent);
        sent++;
      end
      last_hold = bus.o_valid && !bus.i_ready;
      prev_data = bus.o_data;
      prev_tag  = bus.o_tag;
    end
    check("bp sent", sent, 10);
    check("bp received", recv, 10);
    check("bp queue empty", q.size(), 0);

    // Reset with three ops in flight: nothing may emerge afterwards.
    @(negedge clk);
    bus.i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_op(i);
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst mid o_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst mid o_data", bus.o_data, 32'd0);
    rst_n = 1'b1;
    recv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_valid) recv++;
    end
    check("rst dropped ops", recv, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
